jk_driver: RTL
==============

JK_DRIVER -- requirements
Module: jk_driver

Interface
REQ-001 SHALL have parameter CNT_W, default 4, burst-count width in bits.
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-004 SHALL have port cmd_valid, input, 1, command present.
REQ-005 SHALL have port cmd_ready, output, 1, command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-006 SHALL have port cmd_op, input, 3, opcode.
REQ-007 SHALL have port cmd_cnt, input, CNT_W, burst count for BURST; bit 0 is the value for LOAD.
REQ-008 SHALL have port j, output, 1, registered J drive to the downstream JK flip-flop.
REQ-009 SHALL have port k, output, 1, registered K drive to the downstream JK flip-flop.
REQ-010 SHALL have port q_fb, input, 1, observed q of the downstream flip-flop.
REQ-011 SHALL have port model_q, output, 1, shadow model of the downstream q.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-013 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-014 SHALL have port mismatch, output, 1, sticky feedback-error flag.

Function
REQ-015 SHALL decode opcodes as {j,k}: 000 HOLD=00; 001 CLEAR=01; 010 SET=10; 011 TOGGLE=11; 100 LOAD=10 if cmd_cnt[0] else 01; 101 BURST=11 repeated cmd_cnt times; 110/111 SHALL behave as HOLD.
REQ-016 SHALL implement an FSM with states IDLE, DRIVE and CHECK; cmd_ready SHALL be 1 only in IDLE.
REQ-017 On acceptance in IDLE: SHALL register j,k to the decoded pair, load the remaining count (1 for single ops, cmd_cnt for BURST) and enter DRIVE.
REQ-018 BURST with cmd_cnt=0: SHALL keep j=k=0 and go IDLE->CHECK directly; model_q unchanged.
REQ-019 In DRIVE, at each edge: SHALL update model_q per the JK rule from the current j,k (00 hold, 01 0, 10 1, 11 ~model_q) and decrement count; when count is 1, SHALL clear j,k to 00 and enter CHECK.
REQ-020 j,k SHALL be 00 in every state except DRIVE.
REQ-021 CHECK SHALL last exactly one cycle, assert done during it, and return to IDLE.
REQ-022 Single-op latency: accept at edge 0; j,k valid in cycles 0-1; model_q updated at edge 1; done high in cycles 1-2; cmd_ready high again after edge 2.
REQ-023 A BURST of N SHALL hold j=k=1 for exactly N consecutive cycles and toggle model_q N times; done SHALL follow 1 cycle after the last toggle.
REQ-024 cmd_op and cmd_cnt SHALL be sampled only at acceptance; later changes SHALL have no effect.
REQ-025 At the edge ending CHECK, mismatch SHALL be set if q_fb != model_q; once set it SHALL stay 1 until reset.

Reset
REQ-026 With rst_n=0 at a rising edge: state=IDLE, j=0, k=0, model_q=0, count=0, mismatch=0. done, busy and cmd_ready SHALL then be 0, 0 and 1.
REQ-027 Reset during DRIVE or CHECK SHALL abort the command without asserting done; rst_n=0 SHALL override cmd_valid in the same cycle.

Configuration
REQ-028 Macro JK_DRIVER_CHECK_EN: when defined, SHALL implement REQ-025.
REQ-029 When JK_DRIVER_CHECK_EN is undefined: mismatch SHALL be constant 0 and q_fb SHALL be ignored; all other behaviour and timing SHALL be unchanged.

Verification
REQ-030 Reset, then SET, CLEAR, TOGGLE, each with a real JK flop on j/k/q_fb -> model_q = 1, 0, 1; q_fb matches; one done per command; mismatch=0.
REQ-031 BURST with cmd_cnt=5 from model_q=0 -> j=k=1 for exactly 5 cycles; model_q=1; done 1 cycle after the last toggle; busy for 6 cycles.
REQ-032 BURST with cmd_cnt=0 -> j,k stay 00; done in the cycle after acceptance; model_q unchanged.
REQ-033 cmd_valid held high for back-to-back LOAD 1 then LOAD 0 -> the second is accepted only after done; model_q = 1 then 0; opcode 111 acts as HOLD.
REQ-034 With JK_DRIVER_CHECK_EN defined, force q_fb=0 during SET -> mismatch=1 after CHECK and still 1 after the next correct command; undefined build -> mismatch stays 0.
REQ-035 Assert rst_n=0 in the third cycle of BURST cmd_cnt=8 -> the next edge gives IDLE, j=k=0, model_q=0, no done pulse.

Source files
------------

// File: rtl/jk_driver.sv
// Command-driven J/K drive for an external JK flip-flop, with a shadow q model.
// Optional feedback checking of q_fb against the model is enabled by JK_DRIVER_CHECK_EN.
module jk_driver #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic             j,
  output logic             k,
  input  logic             q_fb,
  output logic             model_q,
  output logic             busy,
  output logic             done,
  output logic             mismatch
);

  localparam logic [2:0] OP_CLEAR  = 3'b001;
  localparam logic [2:0] OP_SET    = 3'b010;
  localparam logic [2:0] OP_TOGGLE = 3'b011;
  localparam logic [2:0] OP_LOAD   = 3'b100;
  localparam logic [2:0] OP_BURST  = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [1:0]       dec_jk_c;
  logic [CNT_W-1:0] dec_cnt_c;
  logic             burst_zero_c;
  logic             accept_c;
  logic             j_nxt;
  logic             k_nxt;
  logic             model_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic             ready_nxt;

  assign accept_c = cmd_valid && cmd_ready;

  // Opcode decode into the {j,k} pair and the number of drive cycles
  always_comb begin
    dec_jk_c  = 2'b00;
    dec_cnt_c = CNT_W'(1);
    unique case (cmd_op)
      OP_CLEAR:  dec_jk_c = 2'b01;
      OP_SET:    dec_jk_c = 2'b10;
      OP_TOGGLE: dec_jk_c = 2'b11;
      OP_LOAD:   dec_jk_c = cmd_cnt[0] ? 2'b10 : 2'b01;
      OP_BURST: begin
        dec_jk_c  = 2'b11;
        dec_cnt_c = cmd_cnt;
      end
      default:   dec_jk_c = 2'b00;
    endcase
  end

  assign burst_zero_c = (cmd_op == OP_BURST) && (cmd_cnt == '0);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept_c) state_nxt = burst_zero_c ? CHECK : DRIVE;
      end
      DRIVE: begin
        if (count <= CNT_W'(1)) state_nxt = CHECK;
      end
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    j_nxt     = 1'b0;
    k_nxt     = 1'b0;
    count_nxt = count;
    model_nxt = model_q;
    unique case (state)
      IDLE: begin
        if (accept_c) begin
          if (burst_zero_c) begin
            count_nxt = '0;
          end else begin
            {j_nxt, k_nxt} = dec_jk_c;
            count_nxt      = dec_cnt_c;
          end
        end
      end
      DRIVE: begin
        unique case ({j, k})
          2'b01:   model_nxt = 1'b0;
          2'b10:   model_nxt = 1'b1;
          2'b11:   model_nxt = ~model_q;
          default: model_nxt = model_q;
        endcase
        count_nxt = count - CNT_W'(1);
        if (state_nxt == DRIVE) {j_nxt, k_nxt} = {j, k};
      end
      default: begin
        j_nxt = 1'b0;
        k_nxt = 1'b0;
      end
    endcase
    busy_nxt  = (state_nxt != IDLE);
    done_nxt  = (state_nxt == CHECK);
    ready_nxt = (state_nxt == IDLE);
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      j         <= 1'b0;
      k         <= 1'b0;
      count     <= '0;
      model_q   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      j         <= j_nxt;
      k         <= k_nxt;
      count     <= count_nxt;
      model_q   <= model_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      cmd_ready <= ready_nxt;
    end
  end

`ifdef JK_DRIVER_CHECK_EN
  // Sticky flag: downstream q disagreed with the model when a command finished
  always_ff @(posedge clk) begin
    if (!rst_n)                                mismatch <= 1'b0;
    else if (state == CHECK && q_fb != model_q) mismatch <= 1'b1;
  end
`else
  logic unused_q_fb;
  assign unused_q_fb = q_fb;
  assign mismatch    = 1'b0;
`endif

endmodule
